// File: rtl/conveyor_writer.sv
// conveyor_writer: reserves conveyor slots for long-latency results and later
// fills them with {finished, fault, value} entries.
// Completions come from two producers, each with its own small FIFO.
// A round-robin arbiter drains the FIFOs onto one registered write port.
// Reservations always win the write port.
// Optional feature macro: CONVEYOR_STRAY_CHECK_EN. When it is defined, a
// completion aimed at a slot that is not pending is dropped and `stray`
// pulses instead of a write.
//
// Handshake: a producer transfer happens on the rising clk edge where
// p_valid[i] && p_ready[i]. p_ready[i] is derived only from registered FIFO
// occupancy, so it never depends on p_valid[i] or on the same cycle's pop.
module conveyor_writer #(
   parameter int  WORD_WIDTH          = 32,
   parameter int  CONVEYOR_ADDR_WIDTH = 4,
   parameter int  FIFO_ADDR_WIDTH     = 1,
   localparam int FAULT_ADDR_WIDTH    = 3,
   localparam int ENTRY_WIDTH         = 1 + FAULT_ADDR_WIDTH + WORD_WIDTH
) (
   input  logic                                           clk,
   input  logic                                           reset,
   input  logic                                           reserve_valid,
   input  logic                                           reserve_sel,
   input  logic [CONVEYOR_ADDR_WIDTH-1:0]                 reserve_addr,
   input  logic [1:0]                                     p_valid,
   output logic [1:0]                                     p_ready,
   input  logic [1:0]                                     p_sel,
   input  logic [1:0][CONVEYOR_ADDR_WIDTH-1:0]            p_addr,
   input  logic [1:0][FAULT_ADDR_WIDTH-1:0]               p_fault,
   input  logic [1:0][WORD_WIDTH-1:0]                     p_value,
   output logic                                           wr_en,
   output logic                                           wr_sel,
   output logic [CONVEYOR_ADDR_WIDTH-1:0]                 wr_addr,
   output logic [ENTRY_WIDTH-1:0]                         wr_data,
   output logic                                           idle,
   output logic                                           stray
);
   localparam int SLOTS  = 1 << CONVEYOR_ADDR_WIDTH;
   localparam int DEPTH  = 1 << FIFO_ADDR_WIDTH;
   localparam int CNT_W  = FIFO_ADDR_WIDTH + 1;
   localparam int ITEM_W = 1 + CONVEYOR_ADDR_WIDTH + FAULT_ADDR_WIDTH + WORD_WIDTH;

   // Per-producer FIFO storage; each item is {sel, addr, fault, value}.
   logic [ITEM_W-1:0]          mem_q    [2][DEPTH];
   logic [FIFO_ADDR_WIDTH-1:0] wr_ptr_q [2];
   logic [FIFO_ADDR_WIDTH-1:0] rd_ptr_q [2];
   logic [CNT_W-1:0]           count_q  [2];

   // One pending bit per slot per conveyor.
   logic [1:0][SLOTS-1:0] pending_q;
   // Round-robin pointer: the producer that gets first look next cycle.
   logic rr_q;

   logic                           wr_en_q;
   logic                           wr_sel_q;
   logic [CONVEYOR_ADDR_WIDTH-1:0] wr_addr_q;
   logic [ENTRY_WIDTH-1:0]         wr_data_q;

   logic [1:0]                     head_valid;
   logic [1:0]                     push;
   logic [1:0]                     pop;
   logic                           grant;
   logic                           winner;
   logic [ITEM_W-1:0]              win_item;
   logic                           win_sel;
   logic [CONVEYOR_ADDR_WIDTH-1:0] win_addr;
   logic [FAULT_ADDR_WIDTH-1:0]    win_fault;
   logic [WORD_WIDTH-1:0]          win_value;
   logic                           do_write;

   // FIFO status from registered occupancy only.
   always_comb begin
      for (int i = 0; i < 2; i++) begin
         head_valid[i] = (count_q[i] != '0);
         p_ready[i]    = (count_q[i] != CNT_W'(DEPTH));
         push[i]       = p_valid[i] & p_ready[i];
      end
   end

   // Write-port arbitration: a reservation blocks all FIFO grants this cycle,
   // which also covers a head that collides with the reserved slot.
   always_comb begin
      grant  = 1'b0;
      winner = rr_q;
      pop    = 2'b00;
      if (!reserve_valid && (head_valid != 2'b00)) begin
         grant       = 1'b1;
         winner      = head_valid[rr_q] ? rr_q : ~rr_q;
         pop[winner] = 1'b1;
      end
   end

   assign win_item = mem_q[winner][rd_ptr_q[winner]];
   assign {win_sel, win_addr, win_fault, win_value} = win_item;

`ifdef CONVEYOR_STRAY_CHECK_EN
   logic win_pending;
   logic stray_q;

   assign win_pending = pending_q[win_sel][win_addr];
   assign do_write    = grant & win_pending;
   assign stray       = stray_q;

   // Flag a granted head whose slot was never reserved; it is popped silently.
   always_ff @(posedge clk) begin
      if (reset) begin
         stray_q <= 1'b0;
      end else begin
         stray_q <= grant & ~win_pending;
      end
   end
`else
   assign do_write = grant;
   assign stray    = 1'b0;
`endif

   // FIFO pointers and occupancy; push and pop may coincide.
   always_ff @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (reset) begin
            wr_ptr_q[i] <= '0;
            rd_ptr_q[i] <= '0;
            count_q[i]  <= '0;
         end else begin
            if (push[i]) wr_ptr_q[i] <= wr_ptr_q[i] + FIFO_ADDR_WIDTH'(1);
            if (pop[i])  rd_ptr_q[i] <= rd_ptr_q[i] + FIFO_ADDR_WIDTH'(1);
            count_q[i] <= count_q[i] + CNT_W'(push[i]) - CNT_W'(pop[i]);
         end
      end
   end

   // FIFO storage writes; contents need no reset because occupancy gates reads.
   always_ff @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (push[i]) mem_q[i][wr_ptr_q[i]] <= {p_sel[i], p_addr[i], p_fault[i], p_value[i]};
      end
   end

   // Registered write port, pending bitmap and round-robin pointer.
   always_ff @(posedge clk) begin
      if (reset) begin
         pending_q <= '0;
         rr_q      <= 1'b0;
         wr_en_q   <= 1'b0;
         wr_sel_q  <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
      end else begin
         wr_en_q <= 1'b0;
         if (grant) rr_q <= ~winner;
         if (reserve_valid) begin
            wr_en_q   <= 1'b1;
            wr_sel_q  <= reserve_sel;
            wr_addr_q <= reserve_addr;
            wr_data_q <= '0;
            pending_q[reserve_sel][reserve_addr] <= 1'b1;
         end else if (do_write) begin
            wr_en_q   <= 1'b1;
            wr_sel_q  <= win_sel;
            wr_addr_q <= win_addr;
            wr_data_q <= {1'b1, win_fault, win_value};
            pending_q[win_sel][win_addr] <= 1'b0;
         end
      end
   end

   assign wr_en   = wr_en_q;
   assign wr_sel  = wr_sel_q;
   assign wr_addr = wr_addr_q;
   assign wr_data = wr_data_q;
   assign idle    = (pending_q == '0) && (head_valid == 2'b00);

endmodule

// File: tb/tb_conveyor_writer.sv
// Testbench for conveyor_writer: directed vector table, hand-written corner
// sequences and a randomized run against a queue-based reference model.
module tb_conveyor_writer;
   localparam int W     = 32;
   localparam int AW    = 4;
   localparam int FAW   = 1;
   localparam int DEPTH = 2;
   localparam int EW    = 1 + 3 + W;
`ifdef CONVEYOR_STRAY_CHECK_EN
   localparam bit STRAY_MODE = 1'b1;
`else
   localparam bit STRAY_MODE = 1'b0;
`endif

   // ---------------- clock / reset / DUT ----------------
   logic                 clk = 1'b0;
   logic                 reset;
   logic                 reserve_valid;
   logic                 reserve_sel;
   logic [AW-1:0]        reserve_addr;
   logic [1:0]           p_valid;
   logic [1:0]           p_ready;
   logic [1:0]           p_sel;
   logic [1:0][AW-1:0]   p_addr;
   logic [1:0][2:0]      p_fault;
   logic [1:0][W-1:0]    p_value;
   logic                 wr_en;
   logic                 wr_sel;
   logic [AW-1:0]        wr_addr;
   logic [EW-1:0]        wr_data;
   logic                 idle;
   logic                 stray;

   conveyor_writer #(
      .WORD_WIDTH(W), .CONVEYOR_ADDR_WIDTH(AW), .FIFO_ADDR_WIDTH(FAW)
   ) dut (
      .clk(clk), .reset(reset),
      .reserve_valid(reserve_valid), .reserve_sel(reserve_sel), .reserve_addr(reserve_addr),
      .p_valid(p_valid), .p_ready(p_ready), .p_sel(p_sel), .p_addr(p_addr),
      .p_fault(p_fault), .p_value(p_value),
      .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr), .wr_data(wr_data),
      .idle(idle), .stray(stray)
   );

   always #5 clk = ~clk;

   // ---------------- checking ----------------
   int checks = 0;
   int errors = 0;

   function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endfunction

   // ---------------- reference model ----------------
   typedef struct packed {
      logic          sel;
      logic [AW-1:0] addr;
      logic [2:0]    fault;
      logic [W-1:0]  value;
   } item_t;

   item_t            mq0[$];
   item_t            mq1[$];
   bit               m_pend [2][16];
   int               m_rr;
   logic             m_wen;
   logic             m_stray;
   logic             m_wsel;
   logic [AW-1:0]    m_waddr;
   logic [EW-1:0]    m_wdata;
   logic [AW+EW:0]   exp_q[$];

   function automatic void model_clear();
      mq0.delete();
      mq1.delete();
      exp_q.delete();
      for (int s = 0; s < 2; s++)
         for (int a = 0; a < 16; a++) m_pend[s][a] = 1'b0;
      m_rr    = 0;
      m_wen   = 1'b0;
      m_stray = 1'b0;
      m_wsel  = 1'b0;
      m_waddr = '0;
      m_wdata = '0;
   endfunction

   function automatic logic model_idle();
      if (mq0.size() != 0 || mq1.size() != 0) return 1'b0;
      for (int s = 0; s < 2; s++)
         for (int a = 0; a < 16; a++)
            if (m_pend[s][a]) return 1'b0;
      return 1'b1;
   endfunction

   // ---------------- driver ----------------
   task automatic idle_inputs();
      reserve_valid = 1'b0;
      reserve_sel   = 1'b0;
      reserve_addr  = '0;
      p_valid       = 2'b00;
      p_sel         = 2'b00;
      p_addr        = '0;
      p_fault       = '0;
      p_value       = '0;
   endtask

   // Predict one clock from the inputs currently driven, advance the clock,
   // then compare every DUT output against the model.
   task automatic cycle();
      bit [1:0]       rdy;
      item_t          it;
      int             w;
      logic [AW+EW:0] exp_ent;
      rdy[0]  = (mq0.size() < DEPTH);
      rdy[1]  = (mq1.size() < DEPTH);
      m_wen   = 1'b0;
      m_stray = 1'b0;
      if (reset) begin
         model_clear();
      end else begin
         if (reserve_valid) begin
            m_wen   = 1'b1;
            m_wsel  = reserve_sel;
            m_waddr = reserve_addr;
            m_wdata = '0;
            m_pend[reserve_sel][reserve_addr] = 1'b1;
         end else if (mq0.size() + mq1.size() > 0) begin
            if (m_rr == 0) w = (mq0.size() > 0) ? 0 : 1;
            else           w = (mq1.size() > 0) ? 1 : 0;
            if (w == 0) it = mq0.pop_front();
            else        it = mq1.pop_front();
            m_rr = 1 - w;
            if (STRAY_MODE && !m_pend[it.sel][it.addr]) begin
               m_stray = 1'b1;
            end else begin
               m_wen   = 1'b1;
               m_wsel  = it.sel;
               m_waddr = it.addr;
               m_wdata = {1'b1, it.fault, it.value};
               m_pend[it.sel][it.addr] = 1'b0;
            end
         end
         if (p_valid[0] && rdy[0]) mq0.push_back(item_t'({p_sel[0], p_addr[0], p_fault[0], p_value[0]}));
         if (p_valid[1] && rdy[1]) mq1.push_back(item_t'({p_sel[1], p_addr[1], p_fault[1], p_value[1]}));
      end
      if (m_wen) exp_q.push_back({m_wsel, m_waddr, m_wdata});
      @(posedge clk);
      #1;
      chk("wr_en", wr_en, m_wen);
      if (exp_q.size() > 0) begin
         exp_ent = exp_q.pop_front();
         chk("wr_entry", {wr_sel, wr_addr, wr_data}, exp_ent);
      end else begin
         chk("wr_hold", {wr_sel, wr_addr, wr_data}, {m_wsel, m_waddr, m_wdata});
      end
      chk("stray", stray, m_stray);
      chk("idle", idle, model_idle());
      chk("p_ready", p_ready, {mq1.size() < DEPTH, mq0.size() < DEPTH});
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic          rv;
      logic          rsel;
      logic [AW-1:0] raddr;
      logic [1:0]    pv;
      logic [AW-1:0] a0;
      logic [W-1:0]  v0;
      logic [AW-1:0] a1;
      logic [W-1:0]  v1;
      logic [2:0]    f1;
      logic          psel;
      logic          ewen;
      logic          ewsel;
      logic [AW-1:0] ewaddr;
      logic [EW-1:0] ewdata;
      logic          eidle;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(logic rv, logic rsel, logic [AW-1:0] raddr, logic [1:0] pv,
                               logic [AW-1:0] a0, logic [W-1:0] v0, logic [AW-1:0] a1,
                               logic [W-1:0] v1, logic [2:0] f1, logic psel,
                               logic ewen, logic ewsel, logic [AW-1:0] ewaddr,
                               logic [EW-1:0] ewdata, logic eidle);
      vec_t v;
      v.rv = rv; v.rsel = rsel; v.raddr = raddr; v.pv = pv;
      v.a0 = a0; v.v0 = v0; v.a1 = a1; v.v1 = v1; v.f1 = f1; v.psel = psel;
      v.ewen = ewen; v.ewsel = ewsel; v.ewaddr = ewaddr; v.ewdata = ewdata; v.eidle = eidle;
      return v;
   endfunction

   // ---------------- main ----------------
   initial begin : main
      int k;
      bit acc;
      int wen_cnt;
      int stray_cnt;

      idle_inputs();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      model_clear();
      chk("reset_wr_en", wr_en, 1'b0);
      chk("reset_wr_sel", wr_sel, 1'b0);
      chk("reset_wr_addr", wr_addr, 4'd0);
      chk("reset_wr_data", wr_data, 36'd0);
      chk("reset_stray", stray, 1'b0);
      chk("reset_p_ready", p_ready, 2'b11);
      chk("reset_idle", idle, 1'b1);
      reset = 1'b0;

      // rows: reserve, producers, then the expected outputs after the edge
      // arbitration with pointer at producer 0
      tbl.push_back(mk(1,0,3, 2'b00, 0,0, 0,0,0, 0,  1,0,3, 36'h0, 0));
      tbl.push_back(mk(1,0,4, 2'b00, 0,0, 0,0,0, 0,  1,0,4, 36'h0, 0));
      tbl.push_back(mk(0,0,0, 2'b11, 3,32'h11111111, 4,32'h22222222,5, 0,  0,0,0, 36'h0, 0));
      tbl.push_back(mk(0,0,0, 2'b00, 0,0, 0,0,0, 0,  1,0,3, 36'h8_11111111, 0));
      tbl.push_back(mk(0,0,0, 2'b00, 0,0, 0,0,0, 0,  1,0,4, 36'hD_22222222, 1));
      // reserve 5 then complete it from producer 0
      tbl.push_back(mk(1,0,5, 2'b00, 0,0, 0,0,0, 0,  1,0,5, 36'h0, 0));
      tbl.push_back(mk(0,0,0, 2'b01, 5,32'hDEADBEEF, 0,0,0, 0,  0,0,0, 36'h0, 0));
      tbl.push_back(mk(0,0,0, 2'b00, 0,0, 0,0,0, 0,  1,0,5, 36'h8_DEADBEEF, 1));
      // arbitration with pointer advanced to producer 1
      tbl.push_back(mk(1,0,3, 2'b00, 0,0, 0,0,0, 0,  1,0,3, 36'h0, 0));
      tbl.push_back(mk(1,0,4, 2'b00, 0,0, 0,0,0, 0,  1,0,4, 36'h0, 0));
      tbl.push_back(mk(0,0,0, 2'b11, 3,32'h33333333, 4,32'h44444444,1, 0,  0,0,0, 36'h0, 0));
      tbl.push_back(mk(0,0,0, 2'b00, 0,0, 0,0,0, 0,  1,0,4, 36'h9_44444444, 0));
      tbl.push_back(mk(0,0,0, 2'b00, 0,0, 0,0,0, 0,  1,0,3, 36'h8_33333333, 1));
      // reservation colliding with producer 1's head on sel=1 addr=7
      tbl.push_back(mk(1,1,7, 2'b00, 0,0, 0,0,0, 0,  1,1,7, 36'h0, 0));
      tbl.push_back(mk(0,0,0, 2'b10, 0,0, 7,32'h00000077,0, 1,  0,0,0, 36'h0, 0));
      tbl.push_back(mk(1,1,7, 2'b00, 0,0, 0,0,0, 0,  1,1,7, 36'h0, 0));
      tbl.push_back(mk(0,0,0, 2'b00, 0,0, 0,0,0, 0,  1,1,7, 36'h8_00000077, 1));

      for (int r = 0; r < tbl.size(); r++) begin
         idle_inputs();
         reserve_valid = tbl[r].rv;
         reserve_sel   = tbl[r].rsel;
         reserve_addr  = tbl[r].raddr;
         p_valid       = tbl[r].pv;
         p_sel         = {tbl[r].psel, tbl[r].psel};
         p_addr[0]     = tbl[r].a0;
         p_value[0]    = tbl[r].v0;
         p_addr[1]     = tbl[r].a1;
         p_value[1]    = tbl[r].v1;
         p_fault[1]    = tbl[r].f1;
         cycle();
         chk($sformatf("row%0d_wr_en", r), wr_en, tbl[r].ewen);
         if (tbl[r].ewen)
            chk($sformatf("row%0d_entry", r), {wr_sel, wr_addr, wr_data},
                {tbl[r].ewsel, tbl[r].ewaddr, tbl[r].ewdata});
         chk($sformatf("row%0d_idle", r), idle, tbl[r].eidle);
         chk($sformatf("row%0d_p_ready", r), p_ready, 2'b11);
      end

      // backpressure: reservations on addr 9 starve producer 0's three offers
      idle_inputs(); reserve_valid = 1'b1; reserve_addr = 4'd10; cycle();
      idle_inputs(); reserve_valid = 1'b1; reserve_addr = 4'd11; cycle();
      k = 0;
      for (int c = 0; c < 6; c++) begin
         idle_inputs();
         reserve_valid = 1'b1;
         reserve_addr  = 4'd9;
         p_valid[0]    = 1'b1;
         p_addr[0]     = AW'(10 + k);
         p_value[0]    = 32'hA0 + k;
         acc = p_valid[0] && p_ready[0];
         cycle();
         if (acc) k++;
      end
      chk("bp_accepted", k, 2);
      chk("bp_ready_low", p_ready[0], 1'b0);
      idle_inputs();
      cycle();
      chk("bp_drain_first", {wr_en, wr_addr, wr_data[W-1:0]}, {1'b1, 4'd10, 32'hA0});
      cycle();
      chk("bp_drain_second", {wr_en, wr_addr, wr_data[W-1:0]}, {1'b1, 4'd11, 32'hA1});

      // reset with three pending slots (9, 12, 13) and two buffered completions
      idle_inputs(); reserve_valid = 1'b1; reserve_addr = 4'd12; cycle();
      idle_inputs(); reserve_valid = 1'b1; reserve_addr = 4'd13;
      p_valid = 2'b11; p_addr[0] = 4'd12; p_addr[1] = 4'd13;
      p_value[0] = 32'hC0C0; p_value[1] = 32'hC1C1;
      cycle();
      idle_inputs();
      reset = 1'b1;
      cycle();
      reset = 1'b0;
      chk("rst_idle", idle, 1'b1);
      chk("rst_p_ready", p_ready, 2'b11);
      chk("rst_wr_en", wr_en, 1'b0);
      wen_cnt = 0;
      for (int c = 0; c < 4; c++) begin
         cycle();
         wen_cnt += int'(wr_en);
      end
      chk("rst_no_drain", wen_cnt, 0);

      // completion to an unreserved slot
      idle_inputs();
      p_valid[0] = 1'b1; p_addr[0] = 4'd2; p_value[0] = 32'h2222;
      cycle();
      idle_inputs();
      wen_cnt   = 0;
      stray_cnt = 0;
      for (int c = 0; c < 3; c++) begin
         cycle();
         wen_cnt   += int'(wr_en);
         stray_cnt += int'(stray);
      end
      chk("stray_write_count", wen_cnt, STRAY_MODE ? 0 : 1);
      chk("stray_pulse_count", stray_cnt, STRAY_MODE ? 1 : 0);

      // randomized traffic against the model
      for (int c = 0; c < 3000; c++) begin
         reset         = ($urandom_range(0, 299) == 0);
         reserve_valid = ($urandom_range(0, 3) == 0);
         reserve_sel   = 1'($urandom_range(0, 1));
         reserve_addr  = AW'($urandom_range(0, 5));
         for (int i = 0; i < 2; i++) begin
            p_valid[i] = ($urandom_range(0, 2) == 0);
            p_sel[i]   = 1'($urandom_range(0, 1));
            p_addr[i]  = AW'($urandom_range(0, 5));
            p_fault[i] = 3'($urandom_range(0, 7));
            p_value[i] = $urandom;
         end
         cycle();
      end
      reset = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
